div_low: RTL and testbench
==========================

// Module: div_low
// PURPOSE
// - Sequential restoring shift-subtract divider; the inverse of the shift-add
//   multiplier in the same arithmetic library.
// - Accepts an unsigned dividend/divisor pair on a one-cycle data_rdy strobe.
// - Returns quotient and remainder after N iterations, with a one-cycle res_rdy pulse.
// PARAMETERS
// - N  default 8  dividend and quotient width, in bits; also the iteration count
// - M  default 4  divisor and remainder width, in bits
// PORTS
// - clk        in   1  clock; all logic is on the rising edge
// - rstn       in   1  asynchronous active-low reset
// - data_rdy   in   1  operand valid; sampled only in IDLE
// - dividend   in   N  unsigned dividend
// - divisor    in   M  unsigned divisor
// - busy       out  1  high in CALC and DONE
// - res_rdy    out  1  result valid; one-cycle pulse
// - quotient   out  N  unsigned quotient
// - remainder  out  M  unsigned remainder
// - div_err    out  1  divide-by-zero flag; present only with DIV_ZERO_ERR_EN
// BEHAVIOUR
// - Clock and reset: one clock, clk; asynchronous active-low reset, rstn.
// - Reset value: all outputs 0 and state IDLE. Reset mid-operation aborts the
//   operation with no res_rdy pulse.
// - States: IDLE -> CALC -> DONE -> IDLE.
// - IDLE:
//   - If data_rdy=1 at edge E0: capture dividend into Q[N-1:0], divisor into D[M-1:0].
//   - Clear R[M:0], set cnt=0, set zero flag Z=(divisor==0), go to CALC.
// - CALC, one iteration per edge E1..EN:
//   - trial = {R[M-1:0],Q[N-1]} - {1'b0,D}, computed M+1 bits wide.
//   - If trial[M]==0: R<=trial and Q<={Q[N-2:0],1'b1}.
//   - Else: R<={R[M-1:0],Q[N-1]} and Q<={Q[N-2:0],1'b0}.
//   - cnt increments each iteration.
// - Edge EN (cnt==N-1):
//   - Write quotient<=final Q and remainder<=final R[M-1:0].
//   - res_rdy<=1, go to DONE.
// - DONE: at edge EN+1 set res_rdy<=0 and go to IDLE.
// - Latency and throughput:
//   - res_rdy is high exactly one cycle, from EN to EN+1 (N cycles after E0).
//   - Earliest next accept is edge EN+2, so throughput is one operation per N+2 cycles.
// - quotient and remainder hold their values until the next result is written.
//   They are not cleared when res_rdy falls.
// - data_rdy is ignored in CALC and DONE; no queueing.
// - Operand inputs may change after E0 without affecting the result.
// - If data_rdy is held high, a new operation is accepted on every IDLE cycle.
// - Divide by zero (Z=1):
//   - Same latency as a normal operation.
//   - Result is forced to quotient={N{1'b1}} and remainder=0, overriding the datapath.
// - Width rules:
//   - R is M+1 bits so the trial-subtract borrow is visible.
//   - Remainder is always < divisor, so M bits suffice.
//   - No overflow is possible; the quotient fits in N bits for any nonzero divisor.
// CONFIGURATION
// - DIV_ZERO_ERR_EN defined:
//   - Port div_err exists; reset value 0.
//   - div_err<=Z at edge EN; it pulses with res_rdy and is 0 otherwise.
// - DIV_ZERO_ERR_EN undefined:
//   - Port div_err and its register are absent.
//   - Divide-by-zero result values are unchanged: quotient all ones, remainder 0.
// TESTING (N=8, M=4)
// - Normal case: 200/7 -> quotient=28, remainder=4.
//   - res_rdy pulses 8 cycles after the accept edge and lasts exactly 1 cycle.
//   - busy=1 from E0 to EN+1.
// - Edge values:
//   - 255/1 -> 255 rem 0.
//   - 5/9 -> 0 rem 5.
//   - 0/15 -> 0 rem 0.
//   - 255/15 -> 17 rem 0.
// - Divide by zero: 100/0 -> quotient=255, remainder=0.
//   - div_err=1 with res_rdy when DIV_ZERO_ERR_EN is defined.
//   - Build with and without the macro.
// - Ignored strobes and operand changes:
//   - Pulse data_rdy with 50/3 during CALC and DONE of a 200/7 operation.
//   - Change the operand inputs after E0.
//   - Required: a single result, 28 rem 4; no extra res_rdy.
// - Back-to-back: data_rdy held high with 77/6 then 99/10.
//   - Required: results 12 rem 5 and 9 rem 9.
//   - res_rdy pulses 10 cycles apart.
// - Reset mid-operation: assert rstn=0 at iteration 4.
//   - All outputs go to 0 immediately and no res_rdy occurs.
//   - After release, 9/2 -> 4 rem 1.

Source files
------------

// File: rtl/div_low.sv
// Sequential restoring shift-subtract divider (N-bit dividend, M-bit divisor).
// Optional div_err port enabled by defining DIV_ZERO_ERR_EN.
//
// Ports:
//   clk        in   clock, rising edge
//   rstn       in   asynchronous active-low reset
//   data_rdy   in   operand strobe, sampled only while idle
//   dividend   in   N-bit unsigned dividend
//   divisor    in   M-bit unsigned divisor
//   busy       out  high while an operation is in flight (CALC or DONE)
//   res_rdy    out  one-cycle result-valid pulse
//   quotient   out  N-bit quotient, held until the next result
//   remainder  out  M-bit remainder, held until the next result
//   div_err    out  divide-by-zero flag, pulses with res_rdy
//                   (only when DIV_ZERO_ERR_EN is defined)
module div_low #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         data_rdy,
    input  logic [N-1:0] dividend,
    input  logic [M-1:0] divisor,
    output logic         busy,
    output logic         res_rdy,
    output logic [N-1:0] quotient,
    output logic [M-1:0] remainder
`ifdef DIV_ZERO_ERR_EN
    ,
    output logic         div_err
`endif
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [N-1:0]  q_r;
    logic [M-1:0]  d_r;
    // Partial remainder. Between iterations it is always < divisor, so
    // its top bit is always zero and only M bits are stored; the borrow
    // lives in bit M of the M+1-bit trial difference below.
    logic [M-1:0]  r_r;
    logic [CW-1:0] cnt;
    logic          z_r;

    logic [M:0]    shifted;
    logic [M:0]    trial;
    logic [M-1:0]  r_nxt;
    logic [N-1:0]  q_nxt;
    logic          last;
    logic          accept;

    assign accept = (state == IDLE) && data_rdy;
    assign last   = (cnt == CW'(N - 1));
    assign busy   = (state != IDLE);

    // One restoring iteration: shift in the next dividend bit and try
    // to subtract the divisor. A set borrow bit means "restore".
    always_comb begin
        shifted = {r_r, q_r[N-1]};
        trial   = shifted - {1'b0, d_r};
        r_nxt   = shifted[M-1:0];
        q_nxt   = {q_r[N-2:0], 1'b0};
        if (!trial[M]) begin
            r_nxt = trial[M-1:0];
            q_nxt = {q_r[N-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (data_rdy) state_nxt = CALC;
            CALC:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_r <= '0;
            d_r <= '0;
            r_r <= '0;
            cnt <= '0;
            z_r <= 1'b0;
        end else if (accept) begin
            q_r <= dividend;
            d_r <= divisor;
            r_r <= '0;
            cnt <= '0;
            z_r <= (divisor == '0);
        end else if (state == CALC) begin
            q_r <= q_nxt;
            r_r <= r_nxt;
            cnt <= cnt + 1'b1;
        end
    end

    // Result registers only change on the final iteration, so they keep
    // the last result after res_rdy falls. A zero divisor overrides the
    // datapath with the all-ones quotient and zero remainder.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_rdy   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            res_rdy <= 1'b0;
            if (state == CALC && last) begin
                res_rdy   <= 1'b1;
                quotient  <= z_r ? '1 : q_nxt;
                remainder <= z_r ? '0 : r_nxt;
            end
        end
    end

`ifdef DIV_ZERO_ERR_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_err <= 1'b0;
        end else begin
            div_err <= (state == CALC) && last && z_r;
        end
    end
`endif

endmodule

// File: tb/tb_div_low.sv
// Scoreboard bench for div_low: random and directed divisions checked
// against plain integer division, with latency and pulse-width checks.
module tb_div_low;

    localparam int N = 8;
    localparam int M = 4;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         data_rdy = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [M-1:0] divisor = '0;
    logic         busy;
    logic         res_rdy;
    logic [N-1:0] quotient;
    logic [M-1:0] remainder;
`ifdef DIV_ZERO_ERR_EN
    logic         div_err;
`endif

    div_low #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .data_rdy  (data_rdy),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .res_rdy   (res_rdy),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef DIV_ZERO_ERR_EN
        ,
        .div_err   (div_err)
`endif
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     q;
        int     r;
        int     e;
        longint c0;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input longint act,
                         input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input int a, input int b,
                                   input longint c0);
        exp_t x;
        if (b == 0) begin
            x.q = (1 << N) - 1;
            x.r = 0;
            x.e = 1;
        end else begin
            x.q = a / b;
            x.r = a % b;
            x.e = 0;
        end
        x.c0 = c0;
        return x;
    endfunction

    // Monitor: pops one expectation per res_rdy pulse.
    logic prev_rdy = 1'b0;

    always @(negedge clk) begin
        if (!rstn) begin
            prev_rdy = 1'b0;
        end else begin
            if (res_rdy) begin
                check("res_rdy_width", prev_rdy, 0);
                if (sb.size() == 0) begin
                    check("extra_res_rdy", 1, 0);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    check("quotient", quotient, x.q);
                    check("remainder", remainder, x.r);
                    check("latency", cyc, x.c0 + N);
`ifdef DIV_ZERO_ERR_EN
                    check("div_err", div_err, x.e);
`endif
                end
            end else begin
`ifdef DIV_ZERO_ERR_EN
                check("div_err_idle", div_err, 0);
`endif
            end
            prev_rdy = res_rdy;
        end
    end

    // Called on a falling edge; returns on the first falling edge
    // where the DUT is idle.
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    // Issue one operation; leaves on the falling edge after acceptance.
    task automatic issue(input int a, input int b, input bit push);
        @(negedge clk);
        wait_idle();
        data_rdy = 1'b1;
        dividend = N'(a);
        divisor  = M'(b);
        @(posedge clk);
        #1;
        if (push) sb.push_back(model(a, b, cyc));
        @(negedge clk);
        data_rdy = 1'b0;
        check("busy_after_accept", busy, 1);
        dividend = N'($urandom);
        divisor  = M'($urandom);
    endtask

    initial begin
        longint c_first;
        longint c_second;
        int     blen;

        #1;
        check("rst_busy", busy, 0);
        check("rst_res_rdy", res_rdy, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // 200/7 with stray strobes in CALC/DONE and changing operands.
        issue(200, 7, 1);
        blen = 1;
        for (int i = 0; i < 20 && busy; i++) begin
            data_rdy = 1'b1;
            dividend = 8'd50;
            divisor  = 4'd3;
            @(negedge clk);
            if (busy) blen++;
        end
        data_rdy = 1'b0;
        check("busy_len", blen, N + 1);

        issue(255, 1, 1);
        issue(5, 9, 1);
        issue(0, 15, 1);
        issue(255, 15, 1);
        issue(100, 0, 1);

        // Back-to-back with data_rdy held high.
        @(negedge clk);
        wait_idle();
        data_rdy = 1'b1;
        dividend = 8'd77;
        divisor  = 4'd6;
        @(posedge clk);
        #1;
        c_first = cyc;
        sb.push_back(model(77, 6, cyc));
        @(negedge clk);
        dividend = 8'd99;
        divisor  = 4'd10;
        wait_idle();
        @(posedge clk);
        #1;
        c_second = cyc;
        sb.push_back(model(99, 10, cyc));
        @(negedge clk);
        data_rdy = 1'b0;
        check("b2b_spacing", c_second - c_first, N + 2);

        // Reset during iteration 4: no result may appear.
        issue(123, 5, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_res_rdy", res_rdy, 0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        issue(9, 2, 1);

        // Random operations with random idle gaps.
        for (int i = 0; i < 60; i++) begin
            int a;
            int b;
            a = $urandom_range(0, (1 << N) - 1);
            b = ($urandom_range(0, 7) == 0) ? 0
                : $urandom_range(1, (1 << M) - 1);
            issue(a, b, 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        begin
            int n = 0;
            while (sb.size() != 0 && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("drain_left", sb.size(), 0);
        end
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
